mux_8x1: RTL and testbench
==========================

MUX_8X1 -- requirements
Module: mux_8x1

Interface
REQ-001 Parameter RESET_OUT, default 1'b0: value loaded into out_q and cnt-related flags on reset.
REQ-002 Parameter CNT_W, default 16: width of the transition counter (only used when MUX_8X1_TRANS_CNT_EN is defined).
REQ-003 Port clk  input  1: single clock; all state SHALL update on its rising edge only.
REQ-004 Port rst_n  input  1: reset, synchronous, active-low.
REQ-005 Port in  input  8: data inputs; in[k] is candidate k.
REQ-006 Port s  input  3: select, unsigned 0..7.
REQ-007 Port in_valid  input  1: qualifies in/s for the registered path.
REQ-008 Port out  output  1: combinational selected bit.
REQ-009 Port out_q  output  1: registered selected bit.
REQ-010 Port out_valid  output  1: out_q holds a freshly captured value.
REQ-011 Port trans_cnt  output  CNT_W: out_q 0/1 transition count (macro-dependent, see Configuration).

Function
REQ-012 out SHALL equal in[s] at all times, purely combinational, with no dependence on clk, rst_n or in_valid.
REQ-013 Every select value 0..7 SHALL be legal; no X or default case SHALL be reachable.
REQ-014 On a rising clk with rst_n=1 and in_valid=1, out_q SHALL load in[s] and out_valid SHALL be 1 the next cycle (latency 1).
REQ-015 On a rising clk with rst_n=1 and in_valid=0, out_q SHALL hold its value and out_valid SHALL go 0.
REQ-016 A change of s from 7 to 0 (counter wrap) SHALL be treated as an ordinary select change; out follows immediately.
REQ-017 Simultaneous change of in and s SHALL give out = new_in[new_s] with no glitch requirement beyond settled value.

Reset
REQ-018 With rst_n=0 at a rising clk: out_q = RESET_OUT, out_valid = 0, trans_cnt = 0.
REQ-019 Reset SHALL override in_valid in the same cycle; out SHALL remain combinational in[s] during reset.
REQ-020 Reset asserted mid-stream SHALL discard the in-flight capture; the first valid cycle after release behaves per REQ-014.

Configuration
REQ-021 Macro MUX_8X1_TRANS_CNT_EN defined: trans_cnt SHALL increment by 1 on each clock where out_q changes value, saturating at all-ones.
REQ-022 Macro MUX_8X1_TRANS_CNT_EN undefined: trans_cnt SHALL be tied to 0 and no counter logic SHALL be synthesized.

Structure
REQ-023 Package mux_8x1_pkg SHALL hold SEL_W=3, N_IN=8 constants and a sel_t typedef (logic [SEL_W-1:0]).
REQ-024 Sub-module mux_8x1_core SHALL implement the combinational in[s] selection; mux_8x1 instantiates it once and adds registers/counter.

Verification
REQ-025 in=8'b10101010, s swept 0,1,..,7 then wraps to 0 -> out = 0,1,0,1,0,1,0,1,0.
REQ-026 in=8'h01, s=0 then s=1 -> out = 1 then 0; in=8'h80, s=7 -> out = 1.
REQ-027 rst_n=0 for 2 cycles, in=8'hFF, s=3, in_valid=1 -> out_q=RESET_OUT, out_valid=0, out=1 throughout; after release, one cycle later out_q=1, out_valid=1.
REQ-028 in_valid=1 capture out_q=1, then in_valid=0 and in=8'h00 -> out_q stays 1, out_valid=0, out=0.
REQ-029 With MUX_8X1_TRANS_CNT_EN, in=8'hAA, in_valid=1, s incrementing each cycle for 10 cycles after reset -> trans_cnt=9; without macro -> trans_cnt=0.

Source files
------------

// File: rtl/mux_8x1_pkg.sv
// Shared constants and select type for the 8:1 mux block.
package mux_8x1_pkg;

  localparam int SEL_W = 3;
  localparam int N_IN  = 8;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux_8x1_core.sv
// Combinational 8:1 bit select. Every select value 0..7 indexes a real input,
// so there is no default or X path to reach.
module mux_8x1_core
  import mux_8x1_pkg::*;
(
  input  logic [N_IN-1:0] in,
  input  sel_t            s,
  output logic            out
);

  assign out = in[s];

endmodule

// File: rtl/mux_8x1.sv
// 8:1 mux top: combinational out, registered out_q with valid flag, and an
// optional saturating out_q transition counter enabled by the macro
// MUX_8X1_TRANS_CNT_EN (default build: counter absent, trans_cnt tied to 0).
module mux_8x1
  import mux_8x1_pkg::*;
#(
  parameter logic RESET_OUT = 1'b0,
  parameter int   CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  in,
  input  sel_t             s,
  input  logic             in_valid,
  output logic             out,
  output logic             out_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] trans_cnt
);

  logic mux_bit;
  logic data_d, data_q;
  logic vld_d, vld_q;

  mux_8x1_core u_core (
    .in  (in),
    .s   (s),
    .out (mux_bit)
  );

  assign out       = mux_bit;
  assign out_q     = data_q;
  assign out_valid = vld_q;

  // Capture the selected bit when qualified; otherwise hold data and drop valid.
  always_comb begin
    data_d = data_q;
    vld_d  = 1'b0;
    if (in_valid) begin
      data_d = mux_bit;
      vld_d  = 1'b1;
    end
  end

  // Data/valid registers; reset wins over in_valid and discards any capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= RESET_OUT;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

`ifdef MUX_8X1_TRANS_CNT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Count each clock where out_q will change value, sticking at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if ((data_d != data_q) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Transition counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign trans_cnt = cnt_q;
`else
  assign trans_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_8x1.sv
// Self-checking bench for mux_8x1: directed scenarios plus randomized traffic
// against a behavioural model (bit-shift select, per-cycle register model).
module tb_mux_8x1;

  localparam logic RST_V = 1'b0;
  localparam int   CW    = 4;
  localparam int   CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    in;
  logic [2:0]    s;
  logic          in_valid;
  logic          out, out_q, out_valid;
  logic [CW-1:0] trans_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic m_q   = RST_V;
  logic m_vld = 1'b0;
  int   m_cnt = 0;

  always #5 clk = ~clk;

  mux_8x1 #(.RESET_OUT(RST_V), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .s         (s),
    .in_valid  (in_valid),
    .out       (out),
    .out_q     (out_q),
    .out_valid (out_valid),
    .trans_cnt (trans_cnt)
  );

  function automatic logic ref_bit(input logic [7:0] v, input logic [2:0] k);
    return ((v >> k) & 8'd1) != 8'd0;
  endfunction

  function automatic int exp_cnt();
`ifdef MUX_8X1_TRANS_CNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  // Advance the model from the current inputs, then clock the DUT.
  task automatic tick();
    logic nb;
    nb = ref_bit(in, s);
    if (!rst_n) begin
      m_q = RST_V; m_vld = 1'b0; m_cnt = 0;
    end else if (in_valid) begin
      if (nb != m_q && m_cnt < CMAX) m_cnt++;
      m_q = nb; m_vld = 1'b1;
    end else begin
      m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in = 8'h00; s = 3'd0;
    tick(); tick();
    n_cmp++; if (out_q !== RST_V) begin n_bad++; $display("FAIL reset_out_q got %b want %b", out_q, RST_V); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (int'(trans_cnt) !== 0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", trans_cnt); end
  endtask

  task automatic test_sweep();
    logic [8:0] want;
    want = 9'b010101010;  // bit i = expected out at step i (s wraps 7->0)
    rst_n = 1'b1; in_valid = 1'b0; in = 8'b10101010;
    for (int i = 0; i < 9; i++) begin
      s = 3'(i % 8); #1;
      n_cmp++; if (out !== want[i]) begin n_bad++; $display("FAIL sweep s=%0d got %b want %b", s, out, want[i]); end
    end
  endtask

  task automatic test_edges();
    in = 8'h01; s = 3'd0; #1;
    n_cmp++; if (out !== 1'b1) begin n_bad++; $display("FAIL edge_in01_s0 got %b want 1", out); end
    s = 3'd1; #1;
    n_cmp++; if (out !== 1'b0) begin n_bad++; $display("FAIL edge_in01_s1 got %b want 0", out); end
    in = 8'h80; s = 3'd7; #1;
    n_cmp++; if (out !== 1'b1) begin n_bad++; $display("FAIL edge_in80_s7 got %b want 1", out); end
  endtask

  task automatic test_reset_override();
    rst_n = 1'b0; in = 8'hFF; s = 3'd3; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (out_q !== RST_V) begin n_bad++; $display("FAIL ovr_out_q cyc%0d got %b want %b", i, out_q, RST_V); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_valid cyc%0d got %b want 0", i, out_valid); end
      n_cmp++; if (out !== 1'b1) begin n_bad++; $display("FAIL ovr_out cyc%0d got %b want 1", i, out); end
    end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (out_q !== 1'b1) begin n_bad++; $display("FAIL rel_out_q got %b want 1", out_q); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rel_valid got %b want 1", out_valid); end
  endtask

  task automatic test_hold();
    in = 8'hFF; s = 3'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in = 8'h00;
    tick();
    n_cmp++; if (out_q !== 1'b1) begin n_bad++; $display("FAIL hold_out_q got %b want 1", out_q); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL hold_valid got %b want 0", out_valid); end
    n_cmp++; if (out !== 1'b0) begin n_bad++; $display("FAIL hold_out got %b want 0", out); end
  endtask

  task automatic test_trans_cnt();
    int want;
`ifdef MUX_8X1_TRANS_CNT_EN
    want = 9;
`else
    want = 0;
`endif
    rst_n = 1'b0; tick();
    rst_n = 1'b1; in = 8'hAA; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s = 3'(i); tick();
    end
    n_cmp++; if (int'(trans_cnt) !== want) begin n_bad++; $display("FAIL trans_cnt_aa got %0d want %0d", trans_cnt, want); end
  endtask

  task automatic test_saturate();
    rst_n = 1'b0; tick();
    rst_n = 1'b1; in = 8'hAA; in_valid = 1'b1;
    for (int i = 0; i < CMAX + 6; i++) begin
      s = 3'(i); tick();
    end
    n_cmp++; if (int'(trans_cnt) !== exp_cnt()) begin n_bad++; $display("FAIL trans_cnt_sat got %0d want %0d", trans_cnt, exp_cnt()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in       = 8'($urandom);
      s        = 3'($urandom_range(0, 7));
      in_valid = ($urandom_range(0, 3) != 0);
      rst_n    = ($urandom_range(0, 31) != 0);
      #1;
      n_cmp++; if (out !== ref_bit(in, s)) begin n_bad++; $display("FAIL rand_out i=%0d got %b want %b", i, out, ref_bit(in, s)); end
      tick();
      n_cmp++; if (out_q !== m_q) begin n_bad++; $display("FAIL rand_out_q i=%0d got %b want %b", i, out_q, m_q); end
      n_cmp++; if (out_valid !== m_vld) begin n_bad++; $display("FAIL rand_valid i=%0d got %b want %b", i, out_valid, m_vld); end
      n_cmp++; if (int'(trans_cnt) !== exp_cnt()) begin n_bad++; $display("FAIL rand_cnt i=%0d got %0d want %0d", i, trans_cnt, exp_cnt()); end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_edges();
    test_reset_override();
    test_hold();
    test_trans_cnt();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
